// File: rtl/pipe_drain_fifo.sv
// pipe_drain_fifo
// Credit-based landing buffer for a fixed-latency upstream delay line that
// cannot be stalled. Upstream may inject an element only while issue_ready is
// high. An injected element becomes a credit in flight until it emerges on
// in_valid. Every element that emerges has a guaranteed slot in a show-ahead
// FIFO, so a consumer can drain that FIFO at its own pace.
//
// Optional feature: define PIPE_DRAIN_FIFO_ERRCHK_EN to enable the sticky
// protocol-error flag. When the macro is undefined, err is tied low and no
// checking logic is built.
//
// Ports
//   clk         single clock, rising edge
//   rst         asynchronous active-high reset
//   issue_valid upstream injects an element this cycle
//   issue_ready credit available (count + inflight < DEPTH)
//   in_valid    a delay-line element emerges this cycle
//   in_data     payload of the emerging element
//   out_valid   head entry valid
//   out_ready   consumer accepts the head entry
//   out_data    head entry payload (show-ahead)
//   count       number of stored entries
//   inflight    credits issued but not yet arrived
//   err         sticky protocol error (dropped push or orphan arrival)

`ifndef FSIZE
`define FSIZE 8
`endif

module pipe_drain_fifo #(
    parameter int DATA_SIZE = `FSIZE,
    parameter int LATENCY   = 2,
    parameter int DEPTH     = 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 issue_valid,
    output logic                                 issue_ready,
    input  logic                                 in_valid,
    input  logic [DATA_SIZE-1:0]                 in_data,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [DATA_SIZE-1:0]                 out_data,
    output logic [$clog2(DEPTH+1)-1:0]           count,
    output logic [$clog2(LATENCY+DEPTH+1)-1:0]   inflight,
    output logic                                 err
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(LATENCY + DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    // One extra bit so that count + inflight can never overflow.
    localparam int SW = IW + 1;

    logic [DATA_SIZE-1:0] mem [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [IW-1:0] inflight_q, inflight_d;

    logic          full;
    logic          pop;
    logic          push;
    logic          issue_fire;
    logic [SW-1:0] credit_sum;

    assign full       = (count_q == CW'(DEPTH));
    assign out_valid  = (count_q != '0);
    assign pop        = out_valid && out_ready;
    // A full buffer still accepts an arrival when the head leaves in the same cycle.
    assign push       = in_valid && (!full || pop);
    assign credit_sum = SW'(count_q) + SW'(inflight_q);
    assign issue_ready = (credit_sum < SW'(DEPTH));
    assign issue_fire  = issue_valid && issue_ready;

    assign out_data = mem[rd_ptr_q];
    assign count    = count_q;
    assign inflight = inflight_q;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        inflight_d = inflight_q;

        if (push) begin
            wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // An arrival with no credit outstanding leaves inflight at zero.
        if (issue_fire && !in_valid) begin
            inflight_d = inflight_q + IW'(1);
        end else if (!issue_fire && in_valid && (inflight_q != '0)) begin
            inflight_d = inflight_q - IW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            inflight_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= in_data;
        end
    end

`ifdef PIPE_DRAIN_FIFO_ERRCHK_EN
    logic err_q;
    logic drop;
    logic orphan;

    assign drop   = in_valid && full && !pop;
    assign orphan = in_valid && (inflight_q == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (drop || orphan) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_drain_fifo.sv
// Self-checking bench for pipe_drain_fifo with DATA_SIZE=8, LATENCY=2 and DEPTH=4.
// A two-stage upstream delay line is modelled in the bench. A manual override
// on in_valid/in_data lets the bench inject protocol-violating arrivals.

`timescale 1ns/1ps

module tb_pipe_drain_fifo;

`ifdef PIPE_DRAIN_FIFO_ERRCHK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       issue_valid = 1'b0;
    logic       issue_ready;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic [2:0] count;
    logic [2:0] inflight;
    logic       err;

    // Upstream delay line model
    logic       issue_fire = 1'b0;
    logic [7:0] issue_data = 8'h00;
    logic       pv0, pv1;
    logic [7:0] pd0, pd1;
    logic       man_v = 1'b0;
    logic [7:0] man_d = 8'h00;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pv0 <= 1'b0;
            pv1 <= 1'b0;
            pd0 <= 8'h00;
            pd1 <= 8'h00;
        end else begin
            pv0 <= issue_fire;
            pd0 <= issue_data;
            pv1 <= pv0;
            pd1 <= pd0;
        end
    end

    assign in_valid = pv1 | man_v;
    assign in_data  = man_v ? man_d : pd1;

    pipe_drain_fifo #(
        .DATA_SIZE(8),
        .LATENCY  (2),
        .DEPTH    (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .issue_valid(issue_valid),
        .issue_ready(issue_ready),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .count      (count),
        .inflight   (inflight),
        .err        (err)
    );

    // Inputs change just after the falling edge. issue_ready is stable until the next rise.
    task automatic drive(input logic iv, input logic [7:0] d, input logic ordy);
        issue_valid = iv;
        issue_data  = d;
        out_ready   = ordy;
        issue_fire  = iv && issue_ready;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        man_v = 1'b0;
        drive(1'b0, 8'h00, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Issue four credits with the consumer stalled, then let them land.
    task automatic fill4(input logic [7:0] base);
        int hs;
        hs = 0;
        for (int c = 0; c < 8; c++) begin
            drive(1'b1, base + 8'(hs), 1'b0);
            if (issue_fire) hs++;
            step();
        end
        drive(1'b0, 8'h00, 1'b0);
        for (int c = 0; c < 4; c++) step();
        vectors++;
        if (hs !== 4) begin
            miscompares++;
            $display("FAIL fill_handshakes: got %0d expected 4", hs);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
        vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL rst_count: got %0d expected 0", count); end
        vectors++; if (inflight !== 3'd0) begin miscompares++; $display("FAIL rst_inflight: got %0d expected 0", inflight); end
        vectors++; if (issue_ready !== 1'b1) begin miscompares++; $display("FAIL rst_issue_ready: got %b expected 1", issue_ready); end
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL rst_err: got %b expected 0", err); end
        rst = 1'b0;
    endtask

    task automatic test_streaming();
        int   exp_v;
        int   n;
        logic prev_iv;
        exp_v   = 1;
        n       = 1;
        prev_iv = 1'b0;
        for (int c = 0; c < 40; c++) begin
            vectors++;
            if (out_valid !== prev_iv) begin
                miscompares++;
                $display("FAIL stream_out_valid cycle %0d: got %b expected %b", c, out_valid, prev_iv);
            end
            if (out_valid === 1'b1) begin
                vectors++;
                if (out_data !== exp_v[7:0]) begin
                    miscompares++;
                    $display("FAIL stream_data: got %0h expected %0h", out_data, exp_v[7:0]);
                end
                exp_v++;
            end
            prev_iv = in_valid;
            if (n <= 16) begin
                vectors++;
                if (issue_ready !== 1'b1) begin
                    miscompares++;
                    $display("FAIL stream_issue_ready cycle %0d: got %b expected 1", c, issue_ready);
                end
                drive(1'b1, n[7:0], 1'b1);
                n++;
            end else begin
                drive(1'b0, 8'h00, 1'b1);
            end
            step();
        end
        vectors++;
        if (exp_v !== 17) begin
            miscompares++;
            $display("FAIL stream_total: got %0d expected 16", exp_v - 1);
        end
    endtask

    task automatic test_stall();
        fill4(8'h20);
        vectors++; if (issue_ready !== 1'b0) begin miscompares++; $display("FAIL stall_issue_ready: got %b expected 0", issue_ready); end
        vectors++; if (count !== 3'd4) begin miscompares++; $display("FAIL stall_count: got %0d expected 4", count); end
        vectors++; if (inflight !== 3'd0) begin miscompares++; $display("FAIL stall_inflight: got %0d expected 0", inflight); end
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL stall_err: got %b expected 0", err); end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (out_valid !== 1'b1 || out_data !== 8'h20 + 8'(i)) begin
                miscompares++;
                $display("FAIL stall_drain %0d: got v=%b d=%0h expected v=1 d=%0h",
                         i, out_valid, out_data, 8'h20 + 8'(i));
            end
            drive(1'b0, 8'h00, 1'b1);
            step();
        end
        drive(1'b0, 8'h00, 1'b0);
        vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL stall_empty_count: got %0d expected 0", count); end
        vectors++; if (issue_ready !== 1'b1) begin miscompares++; $display("FAIL stall_ready_back: got %b expected 1", issue_ready); end
    endtask

    task automatic test_full();
        logic [7:0] exp_q [4];
        exp_q = '{8'h31, 8'h32, 8'h33, 8'h55};
        fill4(8'h30);
        // Arrival into a full buffer with no pop is dropped.
        man_v = 1'b1;
        man_d = 8'h66;
        drive(1'b0, 8'h00, 1'b0);
        step();
        man_v = 1'b0;
        vectors++; if (count !== 3'd4) begin miscompares++; $display("FAIL drop_count: got %0d expected 4", count); end
        vectors++; if (out_data !== 8'h30) begin miscompares++; $display("FAIL drop_head: got %0h expected 30", out_data); end
        // Arrival into a full buffer with a same-cycle pop; write pointer wraps onto slot 0.
        man_v = 1'b1;
        man_d = 8'h55;
        drive(1'b0, 8'h00, 1'b1);
        step();
        man_v = 1'b0;
        drive(1'b0, 8'h00, 1'b0);
        vectors++; if (count !== 3'd4) begin miscompares++; $display("FAIL full_simul_count: got %0d expected 4", count); end
        vectors++; if (err !== ERR_EXP) begin miscompares++; $display("FAIL full_err: got %b expected %b", err, ERR_EXP); end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (out_valid !== 1'b1 || out_data !== exp_q[i]) begin
                miscompares++;
                $display("FAIL full_drain %0d: got v=%b d=%0h expected v=1 d=%0h",
                         i, out_valid, out_data, exp_q[i]);
            end
            drive(1'b0, 8'h00, 1'b1);
            step();
        end
        drive(1'b0, 8'h00, 1'b0);
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL full_empty: got %b expected 0", out_valid); end
    endtask

    task automatic test_error();
        do_reset();
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL err_cleared: got %b expected 0", err); end
        man_v = 1'b1;
        man_d = 8'h77;
        drive(1'b0, 8'h00, 1'b0);
        step();
        man_v = 1'b0;
        vectors++; if (err !== ERR_EXP) begin miscompares++; $display("FAIL err_set: got %b expected %b", err, ERR_EXP); end
        vectors++; if (count !== 3'd1) begin miscompares++; $display("FAIL orphan_push_count: got %0d expected 1", count); end
        vectors++; if (inflight !== 3'd0) begin miscompares++; $display("FAIL orphan_inflight: got %0d expected 0", inflight); end
        vectors++; if (out_data !== 8'h77) begin miscompares++; $display("FAIL orphan_data: got %0h expected 77", out_data); end
        for (int c = 0; c < 3; c++) step();
        vectors++; if (err !== ERR_EXP) begin miscompares++; $display("FAIL err_sticky: got %b expected %b", err, ERR_EXP); end
        do_reset();
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL err_rst: got %b expected 0", err); end
    endtask

    task automatic test_mid_reset();
        // Handshakes on four edges; arrivals land two edges after each one.
        for (int c = 0; c < 4; c++) begin
            drive(1'b1, 8'h40 + 8'(c), 1'b0);
            step();
        end
        drive(1'b0, 8'h00, 1'b0);
        step();
        vectors++; if (count !== 3'd3) begin miscompares++; $display("FAIL mid_pre_count: got %0d expected 3", count); end
        vectors++; if (inflight !== 3'd1) begin miscompares++; $display("FAIL mid_pre_inflight: got %0d expected 1", inflight); end
        rst = 1'b1;
        #1;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL mid_out_valid: got %b expected 0", out_valid); end
        vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL mid_count: got %0d expected 0", count); end
        vectors++; if (inflight !== 3'd0) begin miscompares++; $display("FAIL mid_inflight: got %0d expected 0", inflight); end
        vectors++; if (issue_ready !== 1'b1) begin miscompares++; $display("FAIL mid_issue_ready: got %b expected 1", issue_ready); end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) step();
        vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL mid_post_count: got %0d expected 0", count); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_streaming();
        test_stall();
        test_full();
        test_error();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
